mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
- Sequences one multiply-accumulate job on the MAC datapath: clears the accumulator, then streams len operand-pair reads from the operand memory.
- Aligns acc_en to the memory's 1-cycle read latency and waits out the MAC pipeline.
- Presents the result with a valid/ready handshake.
- Sits between the host/job issuer and the MAC datapath plus operand RAM; it replaces the fixed 4-beat count of the MAC control unit with a programmable length.

Parameters:
- ADDR_W, 4, operand memory address width; max job length is 2^ADDR_W.
- LEN_W, ADDR_W+1, width of the len input.
- MAC_LAT, 2, MAC pipeline cycles from the last acc_en beat to a stable accumulator; legal range 1..7.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; legal values 1..2^ADDR_W.
- base_addr  in  ADDR_W  first operand address.
- busy  out  1  high whenever state != IDLE.
- err_len  out  1  one-cycle pulse when a start is rejected for an illegal len.
- rd_en  out  1  operand memory read strobe.
- rd_addr  out  ADDR_W  operand memory read address.
- acc_clr  out  1  accumulator clear, one cycle per job.
- acc_en  out  1  accumulate enable; equals rd_en delayed by 1 cycle.
- result_valid  out  1  accumulator result is final.
- result_ready  in  1  consumer accepts the result.
- done  out  1  one-cycle pulse after the result handshake.

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE. All outputs are 0 from the next cycle: busy, err_len, rd_en, rd_addr, acc_clr, acc_en, result_valid, done. Internal idx, drain counter, len and base latches are 0.
- Reset mid-job aborts immediately. There is no partial result and no done pulse.
- All outputs are registered. There is no combinational path from any input to any output.
- Timing convention: edge E0 is the edge that samples start; "cycle k" is the cycle after edge Ek.
- IDLE:
  - start=1 with 1<=len<=2^ADDR_W: latch len and base_addr, go to CLEAR.
  - start=1 with len==0 or len>2^ADDR_W: err_len=1 for cycle 1, stay in IDLE.
- CLEAR (cycle 1): acc_clr=1 for exactly one cycle, then go to FETCH.
- FETCH (cycles 2..len+1):
  - rd_en=1.
  - rd_addr = base + idx, modulo 2^ADDR_W, so it wraps past the top of memory.
  - idx runs 0..len-1.
  - After the beat with idx==len-1, go to DRAIN.
- acc_en: high on cycles 3..len+2, exactly len beats with no gaps.
- DRAIN (cycles len+2..len+2+MAC_LAT): counter runs 1+MAC_LAT cycles. rd_en=0 throughout; the final acc_en beat falls in the first DRAIN cycle.
- HOLD (from cycle len+3+MAC_LAT):
  - result_valid=1 and held until a cycle with result_ready=1.
  - result_ready may already be high on entry; the handshake then completes in the first HOLD cycle.
  - On handshake: next cycle result_valid=0, done=1 for one cycle, state=IDLE.
- start during any non-IDLE state is ignored: not queued, no err_len.
- start in the IDLE cycle where done is high is accepted, giving back-to-back jobs.
- len==2^ADDR_W: every address is read exactly once, with a wrap when base!=0.

Test Plan:
1. Reset, then start with len=4, base=3, MAC_LAT=2:
   - acc_clr at cycle 1.
   - rd_en cycles 2..5 with rd_addr 3,4,5,6.
   - acc_en cycles 3..6.
   - result_valid from cycle 9.
   - with result_ready=1, done at cycle 10 and busy=0 at cycle 10.
2. Wrap: len=4, base=14 (ADDR_W=4) -> rd_addr 14,15,0,1. Then len=16, base=5 -> 16 reads, 5..15 then 0..4, and 16 acc_en beats.
3. Illegal len: start with len=0, then with len=17 -> err_len pulses once each, busy stays 0, and there is no rd_en, acc_clr or acc_en.
4. Backpressure and start while busy:
   - hold result_ready=0 for 5 cycles after result_valid rises -> result_valid stays 1 and done stays 0.
   - pulse start mid-FETCH -> no effect.
   - raise result_ready -> done pulses exactly once.
5. Reset mid-job: drive rst=0 during FETCH of a len=8 job -> all outputs 0 from the next cycle; a new start after release runs a clean job starting with acc_clr.
6. Back-to-back: start held high continuously with len=1 -> second job's acc_clr appears 1 cycle after done. Each job has exactly 1 rd_en and 1 acc_en.

Source files
------------

// File: rtl/mac_sequencer.sv
// Job sequencer for the MAC datapath: clear, stream len operand reads, drain the MAC
// pipeline, then hold the result under a valid/ready handshake.
module mac_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int LEN_W   = ADDR_W + 1,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              err_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, HOLD} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);
    localparam logic [2:0]       LAT_END = 3'(MAC_LAT);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;
    logic              err_nxt, done_nxt;

    logic              busy_d, acc_clr_d, rd_en_d, valid_d;
    logic [ADDR_W-1:0] rd_addr_d;

    // Outputs are flopped from next-state decode so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            len_q        <= '0;
            base_q       <= '0;
            busy         <= 1'b0;
            err_len      <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            acc_clr      <= 1'b0;
            acc_en       <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            cnt          <= cnt_nxt;
            len_q        <= len_nxt;
            base_q       <= base_nxt;
            busy         <= busy_d;
            err_len      <= err_nxt;
            rd_en        <= rd_en_d;
            rd_addr      <= rd_addr_d;
            acc_clr      <= acc_clr_d;
            acc_en       <= rd_en;
            result_valid <= valid_d;
            done         <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        base_nxt  = base_q;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0 && len <= MAX_LEN) begin
                        state_nxt = CLEAR;
                        len_nxt   = len;
                        base_nxt  = base_addr;
                        idx_nxt   = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_nxt = FETCH;
                idx_nxt   = '0;
            end
            FETCH: begin
                if (LEN_W'(idx) == len_q - LEN_W'(1)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    idx_nxt = idx + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // MAC_LAT+1 cycles: the first one carries the final acc_en beat.
                if (cnt == LAT_END) state_nxt = HOLD;
                else                cnt_nxt   = cnt + 3'd1;
            end
            HOLD: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_d    = (state_nxt != IDLE);
        acc_clr_d = (state_nxt == CLEAR);
        rd_en_d   = (state_nxt == FETCH);
        valid_d   = (state_nxt == HOLD);
        // Address arithmetic is ADDR_W wide, so it wraps past the top of memory.
        rd_addr_d = rd_en_d ? base_nxt + idx_nxt : '0;
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: table of job vectors with hand-computed timing,
// plus reset, mid-job reset and back-to-back sequences.
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] len = '0;
    logic [3:0] base_addr = '0;
    logic       result_ready = 1'b0;
    logic       busy, err_len, rd_en, acc_clr, acc_en, result_valid, done;
    logic [3:0] rd_addr;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    mac_sequencer #(.ADDR_W(4), .LEN_W(5), .MAC_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .base_addr(base_addr),
        .busy(busy), .err_len(err_len), .rd_en(rd_en), .rd_addr(rd_addr),
        .acc_clr(acc_clr), .acc_en(acc_en), .result_valid(result_valid),
        .result_ready(result_ready), .done(done)
    );

    typedef struct {
        int len; int base; int bp; int pulse_cyc;
        int exp_err; int exp_clr; int exp_rd_first; int exp_rd_n;
        int exp_acc_first; int exp_acc_n; int exp_valid; int exp_done; int exp_addr_last;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one job at E0, samples cycles 1.. at negedge, then checks the timing record.
    task automatic run_job(input vec_t v, input string tag);
        int clr_c = -1, clr_n = 0, rd_first = -1, rd_n = 0, acc_first = -1, acc_n = 0;
        int valid_c = -1, valid_n = 0, done_c = -1, err_n = 0, busy_n = 0;
        int addr_bad = 0, last_addr = -1, lim;
        @(negedge clk);
        start        = 1'b1;
        len          = v.len[4:0];
        base_addr    = v.base[3:0];
        result_ready = (v.bp == 0);
        lim = (v.exp_done > 0) ? 60 : 8;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (acc_clr) begin clr_n++; if (clr_c < 0) clr_c = c; end
            if (rd_en) begin
                if (rd_first < 0) rd_first = c;
                if (rd_addr != 4'(v.base + rd_n)) addr_bad++;
                last_addr = int'(rd_addr);
                rd_n++;
            end
            if (acc_en) begin acc_n++; if (acc_first < 0) acc_first = c; end
            if (result_valid) begin valid_n++; if (valid_c < 0) valid_c = c; end
            if (err_len) err_n++;
            if (busy) busy_n++;
            if (c == v.pulse_cyc) begin
                start = 1'b1; len = 5'd3; base_addr = 4'd0;
            end else begin
                start = 1'b0;
            end
            result_ready = (v.bp == 0) || (valid_n > v.bp);
            if (done) begin done_c = c; break; end
        end
        start = 1'b0;
        chk({tag, " err_len"},   err_n,     v.exp_err);
        chk({tag, " clr_cyc"},   clr_c,     v.exp_clr);
        chk({tag, " clr_n"},     clr_n,     (v.exp_clr > 0) ? 1 : 0);
        chk({tag, " rd_first"},  rd_first,  v.exp_rd_first);
        chk({tag, " rd_n"},      rd_n,      v.exp_rd_n);
        chk({tag, " addr_seq"},  addr_bad,  0);
        chk({tag, " addr_last"}, last_addr, v.exp_addr_last);
        chk({tag, " acc_first"}, acc_first, v.exp_acc_first);
        chk({tag, " acc_n"},     acc_n,     v.exp_acc_n);
        chk({tag, " valid_cyc"}, valid_c,   v.exp_valid);
        chk({tag, " valid_n"},   valid_n,   (v.exp_done > 0) ? v.exp_done - v.exp_valid : 0);
        chk({tag, " done_cyc"},  done_c,    v.exp_done);
        chk({tag, " busy_n"},    busy_n,    (v.exp_done > 0) ? v.exp_done - 1 : 0);
    endtask

    initial begin
        vec_t rv;
        int clr_n, clr2, done1, rd_n, acc_n, bad;

        //        len base bp pulse err clr rd1 rdn acc1 accn valid done last
        vecs[0] = '{4,  3,  0, 0,  0,  1,  2,  4,  3,  4,  9,  10, 6};
        vecs[1] = '{4,  14, 0, 0,  0,  1,  2,  4,  3,  4,  9,  10, 1};
        vecs[2] = '{16, 5,  0, 0,  0,  1,  2,  16, 3,  16, 21, 22, 4};
        vecs[3] = '{0,  0,  0, 0,  1,  -1, -1, 0,  -1, 0,  -1, -1, -1};
        vecs[4] = '{17, 0,  0, 0,  1,  -1, -1, 0,  -1, 0,  -1, -1, -1};
        vecs[5] = '{1,  0,  0, 0,  0,  1,  2,  1,  3,  1,  6,  7,  0};
        vecs[6] = '{4,  3,  5, 4,  0,  1,  2,  4,  3,  4,  9,  15, 6};
        vecs[7] = '{16, 0,  0, 0,  0,  1,  2,  16, 3,  16, 21, 22, 15};
        vecs[8] = '{2,  15, 0, 3,  0,  1,  2,  2,  3,  2,  7,  8,  0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", int'({busy, err_len, rd_en, rd_addr, acc_clr, acc_en, result_valid, done}), 0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Reset during FETCH of a len=8 job.
        @(negedge clk);
        start = 1'b1; len = 5'd8; base_addr = 4'd2; result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst rd_en_before", int'(rd_en), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst outs", int'({busy, err_len, rd_en, rd_addr, acc_clr, acc_en, result_valid, done}), 0);
        rst = 1'b1;
        rv = '{2, 9, 0, 0, 0, 1, 2, 2, 3, 2, 7, 8, 10};
        run_job(rv, "after_rst");

        // Back-to-back len=1 jobs with start held high.
        clr_n = 0; clr2 = -1; done1 = -1; rd_n = 0; acc_n = 0; bad = 0;
        @(negedge clk);
        start = 1'b1; len = 5'd1; base_addr = 4'd7; result_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (acc_clr) begin clr_n++; if (clr_n == 2) clr2 = c; end
            if (done && done1 < 0) done1 = c;
            if (rd_en) begin rd_n++; if (rd_addr != 4'd7) bad++; end
            if (acc_en) acc_n++;
        end
        start = 1'b0;
        chk("b2b clr_n", clr_n, 3);
        chk("b2b done1", done1, 7);
        chk("b2b clr2", clr2, 8);
        chk("b2b rd_n", rd_n, 3);
        chk("b2b acc_n", acc_n, 3);
        chk("b2b addr", bad, 0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("b2b idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
